// File: rtl/bytes2bits_stream.sv
// Streaming little-endian byte-to-bit repacker: IN_BYTES-byte beats in, D-bit words out.
// Optional BYTES2BITS_MODQ_EN: with D == 12, output words are reduced once modulo 3329.
module bytes2bits_stream #(
  parameter  int IN_BYTES = 4,
  parameter  int D        = 12,
  localparam int IN_W     = IN_BYTES * 8,
  localparam int BUF_W    = IN_W + D - 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            s_valid_i,
  output logic            s_ready_o,
  input  logic [IN_W-1:0] s_data_i,
  input  logic            s_last_i,
  output logic            m_valid_o,
  input  logic            m_ready_i,
  output logic [D-1:0]    m_data_o,
  output logic            m_last_o
);

  localparam int FW = $clog2(BUF_W + 1);
  localparam logic [FW-1:0] D_F    = FW'(D);
  localparam logic [FW-1:0] IN_W_F = FW'(IN_W);

  logic [BUF_W-1:0] buf_q;
  logic [FW-1:0]    fill_q;
  logic             flush_q;
  logic             push;
  logic             pop;
  logic [D-1:0]     raw_word;

  assign s_ready_o = !flush_q && (fill_q < D_F);
  assign m_valid_o = (fill_q >= D_F) || (flush_q && (fill_q != '0));
  assign m_last_o  = flush_q && m_valid_o && (fill_q <= D_F);
  assign push      = s_valid_i && s_ready_o;
  assign pop       = m_valid_o && m_ready_i;
  assign raw_word  = buf_q[D-1:0];

  // Bits at and above fill_q are always zero, so a push can OR the beat in
  // and a partial final word comes out zero-padded for free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q   <= '0;
      fill_q  <= '0;
      flush_q <= 1'b0;
    end else if (push) begin
      buf_q  <= buf_q | (BUF_W'(s_data_i) << fill_q);
      fill_q <= fill_q + IN_W_F;
      if (s_last_i) flush_q <= 1'b1;
    end else if (pop) begin
      buf_q <= buf_q >> D;
      if (fill_q <= D_F) begin
        fill_q  <= '0;
        flush_q <= 1'b0;
      end else begin
        fill_q <= fill_q - D_F;
      end
    end
  end

`ifdef BYTES2BITS_MODQ_EN
  generate
    if (D == 12) begin : g_modq
      assign m_data_o = (raw_word >= 12'd3329) ? (raw_word - 12'd3329) : raw_word;
    end else begin : g_raw
      assign m_data_o = raw_word;
    end
  endgenerate
`else
  assign m_data_o = raw_word;
`endif

endmodule
